// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux through channels 0..3, waits SETTLE_CYCLES on each,
// samples the mux output and publishes a 4-bit snapshot with a one-cycle done pulse.
// Supports single-shot (start) and continuous (cont) scanning.
// Optional feature macro: MUX_SCAN_CHANGE_EN adds a change-detect pulse alongside done.
module mux_scan_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cont,
   input  logic       y_in,
   output logic       s1,
   output logic       s0,
   output logic       busy,
   output logic       done,
   output logic [3:0] data,
   output logic       change
);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

   state_e           state;
   logic [1:0]       ch;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       shadow;
   logic [3:0]       new_data;
   logic             scan_req;
   logic             last_sample;

   // Select lines come straight from the channel register, so they only move on clock edges.
   assign {s1, s0}    = ch;
   assign new_data    = {y_in, shadow};
   assign scan_req    = start | cont;
   assign last_sample = (state == StSample) && (ch == 2'd3);

   // Scan FSM: channel stepping, settle timing, sample capture and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= StIdle;
         ch     <= 2'd0;
         cnt    <= '0;
         shadow <= 3'd0;
         data   <= 4'd0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (scan_req) begin
                  state <= StSettle;
                  ch    <= 2'd0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            StSettle: begin
               if (cnt == CntLast) begin
                  state <= StSample;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            StSample: begin
               if (ch != 2'd3) begin
                  shadow[ch] <= y_in;
                  ch         <= ch + 2'd1;
                  cnt        <= '0;
                  state      <= StSettle;
               end else begin
                  // Only a completed scan touches data; the 3->0 select change happens here.
                  data  <= new_data;
                  ch    <= 2'd0;
                  state <= StDone;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            StDone: begin
               if (scan_req) begin
                  state <= StSettle;
                  ch    <= 2'd0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else begin
                  state <= StIdle;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

`ifdef MUX_SCAN_CHANGE_EN
   logic [3:0] prev;

   // Pulse change with done when the new snapshot differs from the previous one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev   <= 4'd0;
         change <= 1'b0;
      end else begin
         change <= 1'b0;
         if (last_sample) begin
            change <= (new_data != prev);
            prev   <= new_data;
         end
      end
   end
`else
   assign change = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: table-driven single scans with a scoreboard
// of expected snapshots, plus hand-written continuous, reset and SETTLE_CYCLES=1 sequences.
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic [3:0] d_model = 4'd0;
   logic       y_in;
   logic       s1, s0, busy, done, change;
   logic [3:0] data;

   logic       start2 = 1'b0;
   logic       y2 = 1'b0;
   logic       s1b, s0b, busy2, done2, change2;
   logic [3:0] data2;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] sb_q[$];
   logic [3:0] prev_model = 4'd0;

   typedef struct {
      logic [3:0] pat;
      int         extra_k;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   // Behavioural 4:1 mux: D_i = d_model[i]
   assign y_in = d_model[{s1, s0}];

   mux_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .cont   (cont),
      .y_in   (y_in),
      .s1     (s1),
      .s0     (s0),
      .busy   (busy),
      .done   (done),
      .data   (data),
      .change (change)
   );

   mux_scan_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start2),
      .cont   (1'b0),
      .y_in   (y2),
      .s1     (s1b),
      .s0     (s0b),
      .busy   (busy2),
      .done   (done2),
      .data   (data2),
      .change (change2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pop the scoreboard on a done pulse and compare snapshot, change flag and busy.
   task automatic on_done(input string name);
      logic [3:0] exp;
      logic       exp_chg;
      check({name, "_sb_pending"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
`ifdef MUX_SCAN_CHANGE_EN
         exp_chg = (exp != prev_model);
`else
         exp_chg = 1'b0;
`endif
         prev_model = exp;
         check({name, "_data"}, data, exp);
         check({name, "_change"}, change, exp_chg);
         check({name, "_busy_in_done"}, busy, 0);
      end
   endtask

   // One start-triggered scan; optionally re-pulse start at cycle extra_k (must be ignored).
   task automatic run_scan(input logic [3:0] pat, input int extra_k, input string name);
      int         k;
      int         n;
      bit         sel_ok;
      logic [1:0] exp_sel;
      d_model = pat;
      sb_q.push_back(pat);
      start = 1'b1;
      step();
      start = 1'b0;
      check({name, "_busy_rise"}, busy, 1);
      k = 0;
      sel_ok = 1'b1;
      while (!done && k < 40) begin
         exp_sel = 2'(k / 3);
         if ({s1, s0} !== exp_sel) sel_ok = 1'b0;
         start = (k == extra_k);
         step();
         k++;
      end
      start = 1'b0;
      check({name, "_sel_seq"}, sel_ok, 1);
      check({name, "_latency"}, k, 12);
      if (done) on_done(name);
      check({name, "_sel_in_done"}, {s1, s0}, 0);
      step();
      check({name, "_done_width"}, done, 0);
      n = 0;
      repeat (20) begin
         if (done || busy) n++;
         step();
      end
      check({name, "_quiet_after"}, n, 0);
   endtask

   // Wait for done from the current sample point; drop cont at cycle drop_k.
   task automatic wait_done(input int k0, input int drop_k, output int k);
      k = k0;
      while (!done && k < 60) begin
         if (k == drop_k) cont = 1'b0;
         step();
         k++;
      end
   endtask

   initial begin : main
      int         k;
      int         n;
      logic [3:0] want;

      vecs[0] = '{4'b1101, -1};
      vecs[1] = '{4'b0010, -1};
      vecs[2] = '{4'b1111, 4};
      vecs[3] = '{4'b0000, -1};
      vecs[4] = '{4'b0110, 7};

      // Reset state
      repeat (3) step();
      check("rst_sel", {s1, s0}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data", data, 0);
      check("rst_change", change, 0);
      rst_n = 1'b1;
      step();

      // Table-driven single scans
      for (int i = 0; i < 5; i++) begin
         run_scan(vecs[i].pat, vecs[i].extra_k, $sformatf("vec%0d", i));
      end

      // Continuous mode: cont alone starts from IDLE, then 13-cycle period
      d_model = 4'b0000;
      sb_q.push_back(4'b0000);
      cont = 1'b1;
      wait_done(0, -1, k);
      check("cont0_latency", k, 13);
      on_done("cont0");
      d_model = 4'b1010;
      sb_q.push_back(4'b1010);
      step();
      wait_done(1, -1, k);
      check("cont1_period", k, 13);
      on_done("cont1");
      sb_q.push_back(4'b1010);
      step();
      wait_done(1, -1, k);
      check("cont2_period", k, 13);
      on_done("cont2");
      // Drop cont mid-scan: scan completes, then IDLE
      d_model = 4'b0101;
      sb_q.push_back(4'b0101);
      step();
      wait_done(1, 5, k);
      check("cont3_period", k, 13);
      on_done("cont3");
      step();
      check("cont_stop_sel", {s1, s0}, 0);
      check("cont_stop_done", done, 0);
      n = 0;
      repeat (20) begin
         if (done || busy) n++;
         step();
      end
      check("cont_stop_idle", n, 0);

      // Reset while channel 2 is selected
      d_model = 4'b0111;
      sb_q.push_back(4'b0111);
      start = 1'b1;
      step();
      start = 1'b0;
      k = 0;
      while ({s1, s0} != 2'd2 && k < 40) begin
         step();
         k++;
      end
      check("mid_rst_reach_ch2", {s1, s0}, 2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_sel", {s1, s0}, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_data", data, 0);
      check("mid_rst_change", change, 0);
      sb_q.delete();
      prev_model = 4'd0;
      step();
      step();
      rst_n = 1'b1;
      repeat (5) step();
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_idle_sel", {s1, s0}, 0);
      check("post_rst_idle_data", data, 0);
      run_scan(4'b1011, -1, "post_rst");

      // SETTLE_CYCLES=1 instance: y toggles before each sample edge
      want = 4'b0110;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      k = 0;
      while (!done2 && k < 30) begin
         y2 = (k % 2 == 1) ? want[(k / 2) % 4] : ~want[(k / 2) % 4];
         step();
         k++;
      end
      check("s1_latency", k, 8);
      check("s1_data", data2, want);
`ifdef MUX_SCAN_CHANGE_EN
      check("s1_change", change2, 1);
`else
      check("s1_change", change2, 0);
`endif
      check("s1_busy_in_done", busy2, 0);
      check("s1_sel_in_done", {s1b, s0b}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
